// File: rtl/lfsr_frame_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_frame_gen_pkg
// Description : Shared types and constants for the LFSR frame generator:
//               FSM state encoding, frame length width, header byte count.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_frame_gen_pkg;

    // Frame length field width (lengths up to 2047 bytes)
    localparam int C_LEN_W     = 11;

    // Number of length-header bytes prepended when the header option is built
    localparam int C_HDR_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage : lfsr_frame_gen_pkg
`default_nettype wire

// File: rtl/lfsr_frame_len.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_frame_len
// Description : Registered frame-length clamp. Captures a raw random length
//               when load is high and limits it to [P_MIN_LEN, P_MAX_LEN].
//               One cycle of latency, so a value sampled in LOAD is valid
//               from the first SEND cycle onward.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_frame_len
    import lfsr_frame_gen_pkg::*;
#(
    parameter int P_MIN_LEN = 64,
    parameter int P_MAX_LEN = 1500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [C_LEN_W-1:0] raw_len,
    output logic [C_LEN_W-1:0] len
);

    localparam logic [C_LEN_W-1:0] C_MIN = C_LEN_W'(P_MIN_LEN);
    localparam logic [C_LEN_W-1:0] C_MAX = C_LEN_W'(P_MAX_LEN);

    logic [C_LEN_W-1:0] w_clamped;

    // Saturate the raw length into the legal frame-length window
    always_comb begin
        w_clamped = raw_len;
        if (raw_len < C_MIN) begin
            w_clamped = C_MIN;
        end else if (raw_len > C_MAX) begin
            w_clamped = C_MAX;
        end
    end

    // Hold the clamped length for the whole frame; update only in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            len <= '0;
        end else if (load) begin
            len <= w_clamped;
        end
    end

endmodule : lfsr_frame_len
`default_nettype wire

// File: rtl/lfsr_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_frame_gen
// Description : Random-length, random-payload AXI-Stream frame generator fed
//               by an external free-running LFSR. Bursts of a programmable
//               number of frames (0 = continuous) separated by P_IFG idle
//               cycles. Optional build macro LFSR_FRAME_GEN_LEN_HDR_EN puts
//               the frame length in the first two beats of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_frame_gen
    import lfsr_frame_gen_pkg::*;
#(
    parameter int P_MIN_LEN = 64,
    parameter int P_MAX_LEN = 1500,
    parameter int P_IFG     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_lfsr_value,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_frame_num,
    output logic [7:0]  o_axis_data,
    output logic        o_axis_valid,
    output logic        o_axis_last,
    input  logic        i_axis_ready,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam logic [7:0]         C_GAP_END = 8'(P_IFG - 1);
    localparam logic [C_LEN_W-1:0] C_ONE     = C_LEN_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_target;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        w_cnt_inc;
    logic [C_LEN_W-1:0] r_beat;
    logic [C_LEN_W-1:0] w_len;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         r_payload;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_burst_done;
    logic               w_unused;

    // Upper LFSR bits carry no information for this block
    assign w_unused = ^i_lfsr_value[13:11];

    assign w_xfer       = (r_state == SEND) && i_axis_ready;
    assign w_last_beat  = (r_beat == (w_len - C_ONE));
    assign w_cnt_inc    = r_frame_cnt + 16'd1;
    assign w_burst_done = i_stop || ((r_target != 16'd0) && (w_cnt_inc == r_target));

    // Length is captured from the LFSR during the single LOAD cycle
    lfsr_frame_len #(
        .P_MIN_LEN (P_MIN_LEN),
        .P_MAX_LEN (P_MAX_LEN)
    ) u_len (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (r_state == LOAD),
        .raw_len (i_lfsr_value[C_LEN_W-1:0]),
        .len     (w_len)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; stop only cuts short LOAD/GAP, never a frame in flight
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_state_next = LOAD;
            LOAD: w_state_next = i_stop ? IDLE : SEND;
            SEND: begin
                if (w_xfer && w_last_beat) begin
                    w_state_next = w_burst_done ? IDLE : GAP;
                end
            end
            GAP: begin
                if (i_stop) begin
                    w_state_next = IDLE;
                end else if (r_gap_cnt == C_GAP_END) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Beat index within the frame and idle-cycle count within GAP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat    <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_beat <= '0;
            end else if (w_xfer) begin
                r_beat <= w_last_beat ? '0 : (r_beat + C_ONE);
            end
            r_gap_cnt <= (r_state == GAP) ? (r_gap_cnt + 8'd1) : 8'd0;
        end
    end

    // Burst target latched at start; completed-frame counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target    <= '0;
            r_frame_cnt <= '0;
        end else if ((r_state == IDLE) && i_start) begin
            r_target    <= i_frame_num;
            r_frame_cnt <= '0;
        end else if (w_xfer && w_last_beat) begin
            r_frame_cnt <= w_cnt_inc;
        end
    end

    // Next payload byte: sampled on entry to SEND and after every accepted beat
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_payload <= '0;
        end else if ((r_state == LOAD) || w_xfer) begin
            r_payload <= i_lfsr_value[7:0];
        end
    end

`ifdef LFSR_FRAME_GEN_LEN_HDR_EN
    // Leading beats carry the frame length (high bits first); length is held
    // in a register for the whole frame so a stalled header beat stays stable
    always_comb begin
        o_axis_data = r_payload;
        if ((r_state == SEND) && (r_beat < C_LEN_W'(C_HDR_BYTES))) begin
            o_axis_data = (r_beat == '0) ? {5'b0, w_len[10:8]} : w_len[7:0];
        end
    end
`else
    // Every beat is random payload
    always_comb begin
        o_axis_data = r_payload;
    end
`endif

    assign o_axis_valid = (r_state == SEND);
    assign o_axis_last  = (r_state == SEND) && w_last_beat;
    assign o_busy       = (r_state != IDLE);
    assign o_frame_cnt  = r_frame_cnt;

endmodule : lfsr_frame_gen
`default_nettype wire
